// File: rtl/col_addr_skid_buf_pkg.sv
// Shared memShare definitions for the column-address skid buffer:
// default widths/limits and the buffer FSM state encoding.
package col_addr_skid_buf_pkg;

  // Default column-address width.
  localparam int DEF_COL_ADDR_W = 8;

  // Default maximum number of consecutive replay cycles per pipeline cycle.
  localparam int DEF_MAX_ALLOC_SEQ_NUM = 2;

  // Buffer FSM state encoding (kept as plain constants for legacy tools).
  typedef logic [1:0] skid_state_t;
  localparam skid_state_t ST_EMPTY    = 2'd0;  // nothing held
  localparam skid_state_t ST_OUT_ONLY = 2'd1;  // output register valid
  localparam skid_state_t ST_OUT_SKID = 2'd2;  // output valid + address parked

  // True when the state presents a valid address downstream.
  function automatic logic state_has_output(input skid_state_t s);
    return (s == ST_OUT_ONLY) || (s == ST_OUT_SKID);
  endfunction

endpackage

// File: rtl/col_addr_skid_buf.sv
// Column-address skid buffer: one output register plus one skid register.
// While isColAddr_skid_i is high the current output is replayed and a new
// address is parked; a replay-run counter flags runs that are too long.
module col_addr_skid_buf
  import col_addr_skid_buf_pkg::*;
#(
  parameter int COL_ADDR_W        = DEF_COL_ADDR_W,
  parameter int MAX_ALLOC_SEQ_NUM = DEF_MAX_ALLOC_SEQ_NUM
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic [COL_ADDR_W-1:0] colAddr_i,
  input  logic                  colAddr_vld_i,
  output logic                  colAddr_rdy_o,
  input  logic                  isColAddr_skid_i,
  input  logic                  pipeCycle_begin_i,
  input  logic                  shift_rdy_i,
  output logic [COL_ADDR_W-1:0] colAddr_o,
  output logic                  colAddr_vld_o,
  output logic                  skid_occ_o,
  output logic                  ovf_err_o,
  output logic                  replay_err_o
);

  // The counter must be able to hold MAX_ALLOC_SEQ_NUM+1 (the error level).
  localparam int CNT_W = $clog2(MAX_ALLOC_SEQ_NUM + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ALLOC_SEQ_NUM + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  skid_state_t           state_reg, state_next;
  logic [COL_ADDR_W-1:0] out_reg, out_next;
  logic [COL_ADDR_W-1:0] skid_reg, skid_next;
  logic                  rdy_reg, rdy_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  ovf_reg, ovf_next;
  logic                  rerr_reg, rerr_next;

  logic out_vld;
  logic accept;
  logic consumed;

  assign out_vld  = state_has_output(state_reg);
  assign accept   = colAddr_vld_i & rdy_reg;
  assign consumed = out_vld & shift_rdy_i;

  assign colAddr_o     = out_reg;
  assign colAddr_vld_o = out_vld;
  assign skid_occ_o    = (state_reg == ST_OUT_SKID);
  assign colAddr_rdy_o = rdy_reg;
  assign ovf_err_o     = ovf_reg;
  assign replay_err_o  = rerr_reg;

  // Next-state and datapath selection for the output/skid registers.
  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        // Skid select has no meaning with nothing to replay.
        if (accept) begin
          out_next   = colAddr_i;
          state_next = ST_OUT_ONLY;
        end
      end
      ST_OUT_ONLY: begin
        if (isColAddr_skid_i) begin
          // Replay: output holds even if downstream took it.
          if (accept) begin
            skid_next  = colAddr_i;
            state_next = ST_OUT_SKID;
          end
        end else if (consumed && accept) begin
          out_next = colAddr_i;
        end else if (consumed) begin
          state_next = ST_EMPTY;
        end else if (accept) begin
          skid_next  = colAddr_i;
          state_next = ST_OUT_SKID;
        end
      end
      ST_OUT_SKID: begin
        if (!isColAddr_skid_i && consumed) begin
          out_next   = skid_reg;
          state_next = ST_OUT_ONLY;
        end
      end
      default: begin
        state_next = ST_EMPTY;
      end
    endcase
  end

  // Ready is registered: only the full state refuses new addresses.
  always_comb begin
    rdy_next = (state_next != ST_OUT_SKID);
  end

  // Replay-run counter: pipeline-cycle start restarts the run, and a replay
  // in that same cycle counts as the first cycle of the new run.
  always_comb begin
    cnt_next = cnt_reg;
    if (pipeCycle_begin_i) begin
      cnt_next = (isColAddr_skid_i && out_vld) ? CNT_ONE : '0;
    end else if (!isColAddr_skid_i) begin
      cnt_next = '0;
    end else if (out_vld && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
  end

  // Sticky error flags.
  always_comb begin
    ovf_next  = ovf_reg | (colAddr_vld_i & ~rdy_reg);
    rerr_next = rerr_reg | (cnt_reg == CNT_MAX);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
      rdy_reg   <= 1'b1;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
      rerr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
      rdy_reg   <= rdy_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
      rerr_reg  <= rerr_next;
    end
  end

endmodule

// File: tb/tb_col_addr_skid_buf.sv
// Directed self-checking bench for col_addr_skid_buf with an address
// scoreboard: accepted addresses are queued, and compared when taken.
module tb_col_addr_skid_buf;

  logic       sys_clk;
  logic       rstn;
  logic [7:0] colAddr_i;
  logic       colAddr_vld_i;
  logic       colAddr_rdy_o;
  logic       isColAddr_skid_i;
  logic       pipeCycle_begin_i;
  logic       shift_rdy_i;
  logic [7:0] colAddr_o;
  logic       colAddr_vld_o;
  logic       skid_occ_o;
  logic       ovf_err_o;
  logic       replay_err_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];

  col_addr_skid_buf dut (
    .sys_clk           (sys_clk),
    .rstn              (rstn),
    .colAddr_i         (colAddr_i),
    .colAddr_vld_i     (colAddr_vld_i),
    .colAddr_rdy_o     (colAddr_rdy_o),
    .isColAddr_skid_i  (isColAddr_skid_i),
    .pipeCycle_begin_i (pipeCycle_begin_i),
    .shift_rdy_i       (shift_rdy_i),
    .colAddr_o         (colAddr_o),
    .colAddr_vld_o     (colAddr_vld_o),
    .skid_occ_o        (skid_occ_o),
    .ovf_err_o         (ovf_err_o),
    .replay_err_o      (replay_err_o)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic vld, input logic [7:0] addr, input logic skid,
                       input logic pipe, input logic srdy);
    colAddr_vld_i     = vld;
    colAddr_i         = addr;
    isColAddr_skid_i  = skid;
    pipeCycle_begin_i = pipe;
    shift_rdy_i       = srdy;
  endtask

  // One clock: scoreboard the transfers happening at the coming edge,
  // then advance to just after that edge.
  task automatic step();
    if (rstn) begin
      if (colAddr_vld_o && shift_rdy_i) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'(colAddr_o), 32'hDEAD);
        end else begin
          chk("sb_out", 32'(colAddr_o), 32'(exp_q[0]));
          // A replayed address is taken again later, so keep it queued.
          if (!isColAddr_skid_i) void'(exp_q.pop_front());
        end
      end
      if (colAddr_vld_i && colAddr_rdy_o) exp_q.push_back(colAddr_i);
    end
    @(posedge sys_clk);
    #1;
    $display("t=%0t vld_o=%0b out=0x%02h rdy=%0b skid_occ=%0b ovf=%0b rerr=%0b",
             $time, colAddr_vld_o, colAddr_o, colAddr_rdy_o, skid_occ_o,
             ovf_err_o, replay_err_o);
  endtask

  initial begin
    // Reset state.
    rstn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_vld_o", 32'(colAddr_vld_o), 32'd0);
    chk("rst_out", 32'(colAddr_o), 32'd0);
    chk("rst_rdy", 32'(colAddr_rdy_o), 32'd1);
    chk("rst_skid_occ", 32'(skid_occ_o), 32'd0);
    chk("rst_ovf", 32'(ovf_err_o), 32'd0);
    chk("rst_rerr", 32'(replay_err_o), 32'd0);

    // Streaming with one-cycle latency.
    rstn = 1'b1;
    drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b1); step();
    chk("stream_vld_o", 32'(colAddr_vld_o), 32'd1);
    chk("stream_first", 32'(colAddr_o), 32'h10);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b1); step();
    chk("stream_rdy1", 32'(colAddr_rdy_o), 32'd1);
    drive(1'b1, 8'h12, 1'b0, 1'b0, 1'b1); step();
    chk("stream_rdy2", 32'(colAddr_rdy_o), 32'd1);
    chk("stream_last", 32'(colAddr_o), 32'h12);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("stream_drain", 32'(colAddr_vld_o), 32'd0);

    // One-cycle replay while a new address is parked.
    drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 8'h21, 1'b1, 1'b0, 1'b1); step();
    chk("replay_out", 32'(colAddr_o), 32'h20);
    chk("replay_occ", 32'(skid_occ_o), 32'd1);
    chk("replay_rdy", 32'(colAddr_rdy_o), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("unpark_out", 32'(colAddr_o), 32'h21);
    chk("unpark_occ", 32'(skid_occ_o), 32'd0);
    chk("unpark_rdy", 32'(colAddr_rdy_o), 32'd1);
    step();

    // Overflow while full: address dropped, flag sticky.
    drive(1'b1, 8'h2A, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 8'h2B, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, 8'h30, 1'b1, 1'b0, 1'b1); step();
    chk("ovf_set", 32'(ovf_err_o), 32'd1);
    chk("ovf_occ", 32'(skid_occ_o), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("ovf_next_out", 32'(colAddr_o), 32'h2B);
    step();
    chk("ovf_sticky", 32'(ovf_err_o), 32'd1);
    chk("ovf_empty", 32'(colAddr_vld_o), 32'd0);

    // Replay run of three cycles with no pipeline-cycle start.
    drive(1'b1, 8'h50, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); step(); step(); step();
    chk("rerr_not_yet", 32'(replay_err_o), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("rerr_set", 32'(replay_err_o), 32'd1);
    rstn = 1'b0; step(); exp_q.delete();
    chk("rerr_rst", 32'(replay_err_o), 32'd0);
    chk("ovf_rst", 32'(ovf_err_o), 32'd0);

    // Same run with a pipeline-cycle start on its second cycle.
    rstn = 1'b1;
    drive(1'b1, 8'h51, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1); step();
    chk("pipe_replay_hold", 32'(colAddr_o), 32'h51);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step(); step();
    chk("rerr_clear_run", 32'(replay_err_o), 32'd0);

    // Reset while an address is parked.
    drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 8'h41, 1'b1, 1'b0, 1'b1); step();
    drive(1'b1, 8'h43, 1'b1, 1'b0, 1'b1); step();
    chk("pre_rst_ovf", 32'(ovf_err_o), 32'd1);
    chk("pre_rst_occ", 32'(skid_occ_o), 32'd1);
    rstn = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step(); exp_q.delete();
    chk("mid_rst_vld", 32'(colAddr_vld_o), 32'd0);
    chk("mid_rst_out", 32'(colAddr_o), 32'd0);
    chk("mid_rst_rdy", 32'(colAddr_rdy_o), 32'd1);
    chk("mid_rst_occ", 32'(skid_occ_o), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_err_o), 32'd0);
    rstn = 1'b1;
    drive(1'b1, 8'h42, 1'b0, 1'b0, 1'b1); step();
    chk("post_rst_out", 32'(colAddr_o), 32'h42);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();

    // Downstream stall: output held, then ordered drain.
    drive(1'b1, 8'h60, 1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_hold", 32'(colAddr_o), 32'h60);
    end
    drive(1'b1, 8'h61, 1'b0, 1'b0, 1'b0); step();
    chk("stall_park", 32'(skid_occ_o), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); step();
    chk("stall_next", 32'(colAddr_o), 32'h61);
    step();
    chk("stall_empty", 32'(colAddr_vld_o), 32'd0);
    chk("sb_all_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/col_addr_skid_buf.md
COL_ADDR_SKID_BUF -- requirements
Module: col_addr_skid_buf

Interface
REQ-001 SHALL have parameter COL_ADDR_W, default 8: column-address width.
REQ-002 SHALL have parameter MAX_ALLOC_SEQ_NUM, default 2: maximum number of consecutive skid (replay) cycles allowed in one pipeline cycle of SCU.memShare().
REQ-003 sys_clk  in  1  clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 colAddr_i  in  COL_ADDR_W  column address from the request generator.
REQ-006 colAddr_vld_i  in  1  colAddr_i valid.
REQ-007 colAddr_rdy_o  out  1  buffer can accept; a transfer occurs when vld_i & rdy_o.
REQ-008 isColAddr_skid_i  in  1  skid select from the skid-control generator; 1 = replay the current output, park the new address.
REQ-009 pipeCycle_begin_i  in  1  first cycle of a memShare() pipeline cycle.
REQ-010 shift_rdy_i  in  1  downstream shift unit accepts colAddr_o.
REQ-011 colAddr_o  out  COL_ADDR_W  registered column address to the shift unit.
REQ-012 colAddr_vld_o  out  1  colAddr_o valid.
REQ-013 skid_occ_o  out  1  skid register holds a parked address.
REQ-014 ovf_err_o  out  1  sticky: input presented while colAddr_rdy_o=0.
REQ-015 replay_err_o  out  1  sticky: replay run exceeded MAX_ALLOC_SEQ_NUM cycles.

Function
REQ-016 SHALL implement FSM {EMPTY, OUT_ONLY, OUT_SKID}; colAddr_vld_o=1 in OUT_ONLY/OUT_SKID; skid_occ_o=1 only in OUT_SKID.
REQ-017 colAddr_rdy_o SHALL be registered and equal 1 in EMPTY and OUT_ONLY, and 0 in OUT_SKID.
REQ-018 EMPTY: on accept, load output register from colAddr_i -> OUT_ONLY; isColAddr_skid_i is ignored in EMPTY.
REQ-019 OUT_ONLY with isColAddr_skid_i=0: if output consumed and accept, reload output from colAddr_i (stay); consumed only -> EMPTY; accept without consume -> park in skid register -> OUT_SKID.
REQ-020 OUT_ONLY with isColAddr_skid_i=1: output register SHALL hold regardless of shift_rdy_i (replay); accept -> park in skid register -> OUT_SKID.
REQ-021 OUT_SKID with isColAddr_skid_i=0 and output consumed: output loads from skid register -> OUT_ONLY; otherwise hold.
REQ-022 Input-to-output latency SHALL be 1 cycle when not skidding; a parked address appears on colAddr_o in the cycle after isColAddr_skid_i falls and output is consumed.
REQ-023 Address ordering SHALL be preserved; no address duplicated except by replay, none dropped except on overflow.
REQ-024 colAddr_vld_i=1 while colAddr_rdy_o=0: data dropped, state unchanged, ovf_err_o set.
REQ-025 Replay counter (width clog2(MAX_ALLOC_SEQ_NUM+2)) SHALL increment each cycle isColAddr_skid_i=1 with colAddr_vld_o=1, saturate, clear when isColAddr_skid_i=0; pipeCycle_begin_i=1 SHALL clear it with priority over increment.
REQ-026 replay_err_o SHALL set in the cycle after the counter reaches MAX_ALLOC_SEQ_NUM+1.
REQ-027 Simultaneous pipeCycle_begin_i and isColAddr_skid_i=1: replay still occurs; counter loads 1.

Reset
REQ-028 rstn=0 SHALL force EMPTY, colAddr_o=0, colAddr_vld_o=0, colAddr_rdy_o=1, skid_occ_o=0, skid register=0, replay counter=0, ovf_err_o=0, replay_err_o=0.
REQ-029 Reset mid-operation SHALL discard output and parked addresses in the same edge; first accept allowed the cycle after rstn rises.

Structure
REQ-030 FSM state enum, COL_ADDR_W and MAX_ALLOC_SEQ_NUM defaults SHALL live in the shared memShare package.
REQ-031 No sub-module; output register, skid register, FSM and replay counter SHALL be flat in col_addr_skid_buf.

Verification
REQ-032 Stream 0x10,0x11,0x12 with shift_rdy_i=1, skid=0 -> colAddr_o 0x10,0x11,0x12 one cycle later each, rdy_o stays 1.
REQ-033 Output 0x20, skid=1 for 1 cycle while 0x21 accepted -> colAddr_o=0x20 two cycles, skid_occ_o=1, rdy_o=0, then 0x21.
REQ-034 In OUT_SKID, present 0x30 -> dropped, ovf_err_o=1 sticky, later outputs unaffected.
REQ-035 skid=1 for 3 consecutive cycles (MAX_ALLOC_SEQ_NUM=2), no pipeCycle_begin_i -> replay_err_o=1; repeat with pipeCycle_begin_i on cycle 2 -> replay_err_o=0.
REQ-036 rstn=0 while OUT_SKID holds 0x40/0x41 -> next cycle all outputs at reset values; 0x42 after release appears unaltered.
REQ-037 shift_rdy_i=0 for 4 cycles in OUT_ONLY, then 1 -> colAddr_o held stable, no loss, order preserved.
